bcd_display_mux: RTL
====================

Name: bcd_display_mux

Overview:
Time-multiplexed driver for an N-digit common-segment 7-segment display. It latches a packed BCD word on a load strobe and scans one digit per refresh slot. Per digit it decodes BCD to segments, with leading-zero suppression, per-digit blinking, and invalid-digit flagging. It sits between the user/register interface and the display pins, and is the scanned, clocked successor of the single-digit BCD decoder.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 1000, clock cycles per digit slot (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  strobe; data_in sampled on the rising clk edge where load=1
data_in  in  4*N_DIGITS  packed BCD, digit 0 = bits[3:0] (least significant)
blank_lz  in  1  1 = suppress leading zeros
blink_en  in  N_DIGITS  per-digit blink mask (bit i = digit i)
seg  out  7  segments, active-high, seg[6]=a … seg[0]=g
an  out  N_DIGITS  one-hot digit enable, active-high
err  out  1  1 = stored word contains a nibble > 9
frame_done  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset state: data_reg=0, prescaler=0, idx=0, frame_cnt=0, blink_phase=0, seg=0, an=0, err=0, frame_done=0.
- Load path:
  - load=1 gives data_reg<=data_in at that edge.
  - load is ignored otherwise.
  - load never resets the prescaler or idx.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and idx advances, with idx wrapping N_DIGITS-1 → 0.
- Frame handling, on the edge where idx wraps to 0:
  - frame_done=1 for exactly one cycle.
  - frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles.
- Output registers: seg, an and err at edge t+1 are functions of data_reg, idx and blink_phase as they stand after edge t. Load-to-seg latency is therefore 2 edges.
- an = one-hot(idx). an is never all-zero after reset.
- Decode table, nibble → seg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 = SEG_DASH 0000001
- Digit blanking: seg=0000000 while an stays one-hot, with priority blink over lz over decode. A digit is blanked when:
  - blink_phase=1 and blink_en[idx]=1, or
  - blank_lz=1 and every nibble from N_DIGITS-1 down to idx inclusive equals 0 and idx≠0.
- Leading-zero rules:
  - Digit 0 is never lz-blanked.
  - An invalid nibble counts as non-zero and stops suppression.
- err = OR over digits of (nibble>9), evaluated on data_reg. It is registered and valid one edge after data_reg changes.
- Simultaneous load with idx advance: both take effect at the same edge. The next output uses the new data and the new idx.
- Reset mid-frame: all state returns to reset values on that edge, and scanning restarts at digit 0.
- blank_lz and blink_en are sampled combinationally into the output register and need no handshake.

Decomposition:
- Package bcd_display_pkg holds:
  - SEG_W=7
  - SEG_BLANK=7'b0000000
  - SEG_DASH=7'b0000001
  - SEG_DIGIT[0:9] constants
  - function is_valid_bcd
- Sub-module bcd_seg_lut is a combinational nibble → {seg, valid} lookup using the package constants. It is instantiated once on the muxed nibble.
- Top-level bcd_display_mux holds the counters, the lz/blink logic and the output registers.

Test Plan:
- Bench configuration: N_DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2.
- Reset held 3 cycles, then released → seg=0 and an=0 while rst=1. The first edge after release gives an=0001. an steps 0010, 0100, 1000 every 4 cycles, then 0001 with frame_done=1 for one cycle.
- load data_in=16'h1234, blank_lz=0 → over one frame seg is 0110011 (4) on an=0001, then 1111001 (3), 1101101 (2), 0110000 (1); err=0.
- load 16'h0050, blank_lz=1 → an=1000 and an=0100 give seg=0. an=0010 gives 1011011 (5). an=0001 gives 1111110 (0). With blank_lz=0, digit 3 shows 1111110.
- load 16'h0A07, blank_lz=1 → digit 2 shows 0000001 (A is invalid, so it is not suppressed); digit 3 is blank; err=1 one edge after data_reg updates. Loading 16'h0007 afterwards → err=0.
- blink_en=4'b0001 with data 16'h0008 → digit 0 shows 1111111 for frames 0-1, then 0000000 for frames 2-3, and repeats. Other digits are unaffected.
- load asserted on the prescaler-wrap edge, and rst asserted mid-slot → the new data appears on the new digit at the next edge. rst forces all outputs to 0, and after release the scan restarts at an=0001.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared constants for the scanned BCD display driver: segment encodings
// (seg[6]=a .. seg[0]=g, active-high) and the BCD validity helper.
package bcd_display_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    function automatic logic is_valid_bcd(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational nibble-to-segment lookup; non-BCD nibbles show a dash.
module bcd_seg_lut
    import bcd_display_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o,
    output logic             valid_o
);

    always_comb begin
        seg_o   = SEG_DASH;
        valid_o = is_valid_bcd(nibble_i);
        case (nibble_i)
            4'd0:    seg_o = SEG_DIGIT[0];
            4'd1:    seg_o = SEG_DIGIT[1];
            4'd2:    seg_o = SEG_DIGIT[2];
            4'd3:    seg_o = SEG_DIGIT[3];
            4'd4:    seg_o = SEG_DIGIT[4];
            4'd5:    seg_o = SEG_DIGIT[5];
            4'd6:    seg_o = SEG_DIGIT[6];
            4'd7:    seg_o = SEG_DIGIT[7];
            4'd8:    seg_o = SEG_DIGIT[8];
            4'd9:    seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed N-digit 7-segment driver: latches a packed BCD word and
// scans one digit per slot with leading-zero suppression and per-digit blink.
module bcd_display_mux
    import bcd_display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     blink_en,
    output logic [SEG_W-1:0]        seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    err,
    output logic                    frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*N_DIGITS-1:0] data_q, data_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  phase_q, phase_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  err_q, err_d;
    logic                  fdone_q, fdone_d;

    logic [3:0]       cur_nib;
    logic             lz_hit;
    logic             blink_hit;
    logic             slot_end;
    logic             frame_end;
    logic [SEG_W-1:0] lut_seg;
    logic             lut_valid;

    always_comb begin
        slot_end  = (div_q == DIV_W'(CLK_DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));

        div_d   = slot_end ? '0 : div_q + DIV_W'(1);
        idx_d   = idx_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_end) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end
        fdone_d = frame_end;
        data_d  = load ? data_in : data_q;
    end

    // Walk from the most significant digit down; lz_run stays set only while
    // every nibble seen so far is zero (invalid nibbles count as non-zero).
    always_comb begin
        logic lz_run;
        lz_run    = 1'b1;
        lz_hit    = 1'b0;
        blink_hit = 1'b0;
        cur_nib   = 4'd0;
        err_d     = 1'b0;
        an_d      = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (data_q[4*i +: 4] != 4'd0) begin
                lz_run = 1'b0;
            end
            if (!is_valid_bcd(data_q[4*i +: 4])) begin
                err_d = 1'b1;
            end
            if (idx_q == IDX_W'(i)) begin
                lz_hit    = lz_run && (i != 0);
                blink_hit = blink_en[i];
                cur_nib   = data_q[4*i +: 4];
                an_d[i]   = 1'b1;
            end
        end
    end

    bcd_seg_lut u_lut (
        .nibble_i (cur_nib),
        .seg_o    (lut_seg),
        .valid_o  (lut_valid)
    );

    always_comb begin
        if (phase_q && blink_hit) begin
            seg_d = SEG_BLANK;
        end else if (blank_lz && lz_hit) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = lut_valid ? lut_seg : SEG_DASH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            err_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
            fdone_q <= fdone_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign err        = err_q;
    assign frame_done = fdone_q;

endmodule
